conv1d_out_serializer: RTL
==========================

Name: conv1d_out_serializer

Overview:
Reader side of the conv1d result register bank. It captures one parallel vector of N_OUT results in a single cycle, then streams the lanes out one per beat on a valid/ready interface toward the output FIFO/bus. It sits between the conv1d accumulator/result registers and the core's output port, and provides back-pressure to the datapath through in_ready.

Parameters:
N_BIT, 8, width of one result lane in bits
N_OUT, 4, number of lanes per captured vector (>=2)
CNT_W, 16, width of the completed-frame counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  parallel vector offered by the result bank
in_data  in  N_OUT*N_BIT  lane k occupies bits [(k+1)*N_BIT-1 : k*N_BIT]
in_ready  out  1  serializer accepts a vector this cycle
out_valid  out  1  out_data holds a valid lane
out_ready  in  1  downstream accepts the lane
out_data  out  N_BIT  current lane value
out_idx  out  $clog2(N_OUT)  index of the current lane
out_last  out  1  current beat is lane N_OUT-1
busy  out  1  vector held, drain in progress
frame_cnt  out  CNT_W  number of fully drained vectors, wraps mod 2^CNT_W

Behaviour:
- Reset (rst_n low, async): state=IDLE, buffer=0, idx=0, frame_cnt=0; out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0. in_ready is gated with rst_n and driven 0 while reset is asserted.
- Handshakes: an input transfer happens on in_valid & in_ready. An output beat happens on out_valid & out_ready.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an input transfer: capture in_data into buffer, idx<=0, go to DRAIN.
  - First lane is presented in the next cycle, so capture-to-out_valid latency is 1 cycle.
- DRAIN:
  - out_valid=1, busy=1.
  - out_data=buffer[idx], out_idx=idx, out_last=(idx==N_OUT-1). All are driven from registers through the lane mux.
  - Under back-pressure (out_valid & !out_ready): out_data, out_idx and out_last hold stable.
  - Output beat with idx<N_OUT-1: idx<=idx+1.
  - Output beat with idx==N_OUT-1: frame_cnt<=frame_cnt+1 (wraps), idx<=0.
    - If in_valid is also high, the next vector is captured in the same cycle and the block stays in DRAIN (back-to-back, no bubble).
    - Otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DRAIN & idx==N_OUT-1 & out_ready).
  - This is a combinational out_ready->in_ready path and is documented as such.
  - in_ready never depends on in_valid.
- in_valid is ignored while in_ready=0. The block does not capture or corrupt the buffer, and the source must hold its data.
- Reset asserted mid-drain: the partial frame is discarded, frame_cnt is not incremented, and all outputs return to reset values immediately.
- Width rules: idx is $clog2(N_OUT) bits and is never allowed past N_OUT-1, including for non-power-of-2 N_OUT. Lanes are passed through unmodified, with no sign or width change.

Decomposition:
- Shared package conv1d_pkg:
  - typedef enum logic {IDLE, DRAIN} ser_state_t
  - default N_BIT constant
  - lane-slice helper function
- One natural sub-module: conv1d_lane_mux. It is a parameterised N_OUT:1 mux of N_BIT lanes, selected by idx, and is reusable by other readers of the register bank.
- Everything else stays inline: FSM, idx counter, frame counter.

Test Plan:
- Basic drain (N_BIT=8, N_OUT=4): in_data=0x44332211 with out_ready=1.
  - Expect out_data 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting 1 cycle after capture.
  - Expect out_idx 0..3, out_last only on 0x44, then frame_cnt=1 and return to IDLE.
- Back-pressure: out_ready low for 3 cycles while lane 1 (0x22) is shown.
  - Expect out_data=0x22, out_idx=1 and out_valid=1 held stable throughout.
  - Expect no beat loss; completion is 3 cycles later than the basic case.
- Back-to-back: 0xDDCCBBAA then 0x04030201 offered while the last lane 0xDD is accepted.
  - Expect in_ready=1 in that cycle.
  - Expect the stream 0xAA, 0xBB, 0xCC, 0xDD, 0x01, 0x02, 0x03, 0x04 with no bubble, and frame_cnt=2.
- Input while busy: in_valid=1 with in_data=0xFFFFFFFF during lane 1 of 0x44332211.
  - Expect in_ready=0 and the stream unchanged.
  - The 0xFF.. vector is accepted only at the last beat.
- Reset mid-drain: assert rst_n=0 asynchronously during lane 2.
  - Expect immediate out_valid=0, out_data=0, in_ready=0, and frame_cnt unchanged at 0.
  - After release, expect in_ready=1 and a new vector to drain correctly.
- Counter wrap (CNT_W=2): drain 5 vectors.
  - Expect frame_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/conv1d_pkg.sv
// Shared types and helpers for the conv1d result register bank readers.
package conv1d_pkg;

    typedef enum logic {
        IDLE,
        DRAIN
    } ser_state_t;

    localparam int unsigned N_BIT_DEFAULT = 8;

    // LSB position of lane 'lane' inside a packed vector of n_bit-wide lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned n_bit);
        return lane * n_bit;
    endfunction

endpackage

// File: rtl/conv1d_lane_mux.sv
// N_OUT:1 mux of N_BIT-wide lanes from a packed result-bank vector.
module conv1d_lane_mux
    import conv1d_pkg::*;
#(
    parameter int unsigned N_BIT = N_BIT_DEFAULT,
    parameter int unsigned N_OUT = 4,
    parameter int unsigned SEL_W = $clog2(N_OUT)
) (
    input  logic [N_OUT*N_BIT-1:0] lanes,
    input  logic [SEL_W-1:0]       sel,
    output logic [N_BIT-1:0]       lane
);

    always_comb begin
        lane = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (sel == SEL_W'(k)) begin
                lane = lanes[lane_lsb(k, N_BIT) +: N_BIT];
            end
        end
    end

endmodule

// File: rtl/conv1d_out_serializer.sv
// Captures one N_OUT-lane result vector and streams it out one lane per beat.
module conv1d_out_serializer
    import conv1d_pkg::*;
#(
    parameter int unsigned N_BIT = N_BIT_DEFAULT,
    parameter int unsigned N_OUT = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [N_OUT*N_BIT-1:0]   in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_BIT-1:0]         out_data,
    output logic [$clog2(N_OUT)-1:0] out_idx,
    output logic                     out_last,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_cnt
);

    localparam int unsigned IDX_W = $clog2(N_OUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    ser_state_t             state;
    logic [N_OUT*N_BIT-1:0] buffer;
    logic [IDX_W-1:0]       idx;
    logic                   at_last;
    logic                   in_fire;
    logic                   out_fire;

    assign at_last  = (idx == LAST_IDX);
    // Combinational out_ready -> in_ready path lets the next vector land on the final beat.
    assign in_ready = rst_n & ((state == IDLE) | ((state == DRAIN) & at_last & out_ready));
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    assign out_valid = (state == DRAIN);
    assign busy      = (state == DRAIN);
    assign out_idx   = idx;
    assign out_last  = (state == DRAIN) & at_last;

    conv1d_lane_mux #(
        .N_BIT (N_BIT),
        .N_OUT (N_OUT),
        .SEL_W (IDX_W)
    ) u_lane_mux (
        .lanes (buffer),
        .sel   (idx),
        .lane  (out_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            buffer    <= '0;
            idx       <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        buffer <= in_data;
                        idx    <= '0;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (at_last) begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                            idx       <= '0;
                            if (in_fire) begin
                                buffer <= in_data;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
